// File: rtl/difftest_commit_queue_pkg.sv
// difftest_commit_queue_pkg: commit-record field widths and trap opcode shared with the simulation top
package difftest_commit_queue_pkg;
    localparam logic [6:0] TRAP_OPCODE = 7'h6b;
    localparam int INST_W = 32;
    localparam int WDEST_W = 5;
    localparam int CMT_WDEST_W = 8;
    function automatic logic is_trap(input logic [6:0] opcode);
        return opcode == TRAP_OPCODE;
    endfunction
endpackage

// File: rtl/commit_lane_pack.sv
// commit_lane_pack: prefix-sum compaction of retire lanes with trap-lane masking
//   opcode    : per-lane inst[6:0]
//   valid     : per-lane retire valid
//   keep      : lanes that are actually enqueued (lanes above a trap are dropped)
//   offset    : per-lane slot offset from the write pointer
//   count     : number of kept lanes
//   trap_hit  : a kept lane carries the trap opcode
//   trap_lane : index of that lane
module commit_lane_pack
    import difftest_commit_queue_pkg::*;
#(
    parameter int COMMIT_W = 2,
    parameter int OW = $clog2(COMMIT_W) + 1
) (
    input  logic [COMMIT_W-1:0]    valid,
    input  logic [COMMIT_W*7-1:0]  opcode,
    output logic [COMMIT_W-1:0]    keep,
    output logic [COMMIT_W*OW-1:0] offset,
    output logic [OW-1:0]          count,
    output logic                   trap_hit,
    output logic [OW-1:0]          trap_lane
);
    always_comb begin
        keep = '0;
        offset = '0;
        count = '0;
        trap_hit = 1'b0;
        trap_lane = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            keep[i] = valid[i] && !trap_hit;
            offset[i*OW +: OW] = count;
            if (keep[i]) begin
                count = count + OW'(1);
                if (is_trap(opcode[i*7 +: 7])) begin
                    trap_hit = 1'b1;
                    trap_lane = OW'(i);
                end
            end
        end
    end
endmodule

// File: rtl/difftest_commit_queue.sv
// difftest_commit_queue: program-order commit buffer between retire and the difftest commit/trap channels
//   in_*              : up to COMMIT_W retire records per cycle, accepted only when in_ready
//   drain_en          : allow up to COMMIT_W oldest records onto the registered cmt_* lanes
//   trap_*            : sticky trap status, code taken from a0 at trap enqueue
//   cycle_cnt/instr_cnt : counters that freeze once the trap commits
//   overflow          : sticky, a valid retire group was dropped
module difftest_commit_queue
    import difftest_commit_queue_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int DEPTH = 8,
    parameter int COMMIT_W = 2
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [COMMIT_W-1:0]             in_valid,
    input  logic [COMMIT_W*XLEN-1:0]        in_pc,
    input  logic [COMMIT_W*INST_W-1:0]      in_inst,
    input  logic [COMMIT_W-1:0]             in_wen,
    input  logic [COMMIT_W*WDEST_W-1:0]     in_wdest,
    input  logic [COMMIT_W*XLEN-1:0]        in_wdata,
    input  logic [COMMIT_W-1:0]             in_skip,
    input  logic [XLEN-1:0]                 a0_value,
    output logic                            in_ready,
    input  logic                            drain_en,
    output logic [COMMIT_W-1:0]             cmt_valid,
    output logic [COMMIT_W-1:0]             cmt_wen,
    output logic [COMMIT_W-1:0]             cmt_skip,
    output logic [COMMIT_W*XLEN-1:0]        cmt_pc,
    output logic [COMMIT_W*XLEN-1:0]        cmt_wdata,
    output logic [COMMIT_W*INST_W-1:0]      cmt_inst,
    output logic [COMMIT_W*CMT_WDEST_W-1:0] cmt_wdest,
    output logic                            trap_valid,
    output logic [7:0]                      trap_code,
    output logic [XLEN-1:0]                 trap_pc,
    output logic [63:0]                     cycle_cnt,
    output logic [63:0]                     instr_cnt,
    output logic                            overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int OW = $clog2(COMMIT_W) + 1;

    logic [XLEN-1:0]    q_pc    [DEPTH];
    logic [XLEN-1:0]    q_wdata [DEPTH];
    logic [INST_W-1:0]  q_inst  [DEPTH];
    logic [WDEST_W-1:0] q_wdest [DEPTH];
    logic               q_wen   [DEPTH];
    logic               q_skip  [DEPTH];

    logic [PW-1:0] wptr, rptr, occ, deq_n;
    logic [AW-1:0] wslot [COMMIT_W];
    logic [AW-1:0] rslot [COMMIT_W];
    logic [COMMIT_W*7-1:0] opcode;
    logic [COMMIT_W-1:0] keep;
    logic [COMMIT_W*OW-1:0] offset;
    logic [OW-1:0] count, trap_lane;
    logic trap_hit, trap_seen, enq;
    logic unused_a0;

    assign unused_a0 = ^a0_value[XLEN-1:8];
    assign occ = wptr - rptr;
    // Only free space before this edge's dequeue counts; a trap in the queue closes it for good.
    assign in_ready = !trap_seen && (PW'(DEPTH) - occ >= PW'(COMMIT_W));
    assign enq = in_ready && |in_valid;
    assign deq_n = !drain_en ? '0 : (occ < PW'(COMMIT_W)) ? occ : PW'(COMMIT_W);

    always_comb begin
        opcode = '0;
        wslot = '{default: '0};
        rslot = '{default: '0};
        for (int i = 0; i < COMMIT_W; i++) begin
            opcode[i*7 +: 7] = in_inst[i*INST_W +: 7];
            wslot[i] = wptr[AW-1:0] + AW'(offset[i*OW +: OW]);
            rslot[i] = rptr[AW-1:0] + AW'(i);
        end
    end

    commit_lane_pack #(.COMMIT_W(COMMIT_W)) u_pack (
        .valid(in_valid),
        .opcode(opcode),
        .keep(keep),
        .offset(offset),
        .count(count),
        .trap_hit(trap_hit),
        .trap_lane(trap_lane)
    );

    always_ff @(posedge clock) begin
        if (enq) begin
            for (int i = 0; i < COMMIT_W; i++) begin
                if (keep[i]) begin
                    q_pc[wslot[i]] <= in_pc[i*XLEN +: XLEN];
                    q_wdata[wslot[i]] <= in_wdata[i*XLEN +: XLEN];
                    q_inst[wslot[i]] <= in_inst[i*INST_W +: INST_W];
                    q_wdest[wslot[i]] <= in_wdest[i*WDEST_W +: WDEST_W];
                    q_wen[wslot[i]] <= in_wen[i];
                    q_skip[wslot[i]] <= in_skip[i];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
            trap_seen <= 1'b0;
            trap_valid <= 1'b0;
            trap_code <= '0;
            trap_pc <= '0;
            overflow <= 1'b0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            cmt_valid <= '0;
            cmt_wen <= '0;
            cmt_skip <= '0;
            cmt_pc <= '0;
            cmt_wdata <= '0;
            cmt_inst <= '0;
            cmt_wdest <= '0;
        end else begin
            if (enq) begin
                wptr <= wptr + PW'(count);
                if (trap_hit) begin
                    trap_seen <= 1'b1;
                    trap_code <= a0_value[7:0];
                    trap_pc <= in_pc[int'(trap_lane)*XLEN +: XLEN];
                end
            end
            if (|in_valid && !in_ready && !trap_seen)
                overflow <= 1'b1;
            rptr <= rptr + deq_n;
            for (int j = 0; j < COMMIT_W; j++) begin
                cmt_valid[j] <= PW'(j) < deq_n;
                if (PW'(j) < deq_n) begin
                    cmt_pc[j*XLEN +: XLEN] <= q_pc[rslot[j]];
                    cmt_wdata[j*XLEN +: XLEN] <= q_wdata[rslot[j]];
                    cmt_inst[j*INST_W +: INST_W] <= q_inst[rslot[j]];
                    cmt_wdest[j*CMT_WDEST_W +: CMT_WDEST_W] <= {{(CMT_WDEST_W-WDEST_W){1'b0}}, q_wdest[rslot[j]]};
                    cmt_wen[j] <= q_wen[rslot[j]];
                    cmt_skip[j] <= q_skip[rslot[j]];
                end
            end
            // Nothing enters after the trap, so it is the youngest entry: it commits when the queue drains empty.
            if (trap_seen && deq_n != '0 && rptr + deq_n == wptr)
                trap_valid <= 1'b1;
            if (!trap_valid) begin
                cycle_cnt <= cycle_cnt + 64'd1;
                instr_cnt <= instr_cnt + 64'(deq_n);
            end
        end
    end
endmodule
